// File: rtl/divsqrt_iter_core.sv
// rtl/divsqrt_iter_core.sv - iterative radix-2 unsigned divide / square-root core
// One result bit per BUSY cycle; results held from the DONE edge until the next completion.
module divsqrt_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             div_start_i,
  input  logic             sqrt_start_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             kill_i,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             div_by_zero_o,
  output logic             ready_o,
  output logic             done_o
);

  localparam int H  = WIDTH / 2;
  localparam int SW = H + 5;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_op_div;
  logic             r_dbz;
  logic [WIDTH:0]   r_drem;
  logic [SW-1:0]    r_sr;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_rem;
  logic             r_dbz_out;

  logic             w_start;
  logic             w_last;
  logic [WIDTH:0]   w_drem_sh;
  logic [WIDTH+1:0] w_ddiff;
  logic             w_dbit;
  logic [WIDTH:0]   w_drem_nxt;
  logic [WIDTH-1:0] w_dq_nxt;
  logic [SW-1:0]    w_sr_sh;
  logic [SW-1:0]    w_sq_t;
  logic [SW-1:0]    w_sr_nxt;
  logic [H-1:0]     w_sq_nxt;
  logic [SW-1:0]    w_sr_fix;

  assign w_start = (div_start_i | sqrt_start_i) & ready_o & ~kill_i;
  assign w_last  = (r_state == S_BUSY) && (r_cnt == '0);

  // Restoring divide step: shift in next dividend bit, trial-subtract divisor.
  assign w_drem_sh  = (WIDTH+1)'({r_drem, r_a[WIDTH-1]});
  assign w_ddiff    = {1'b0, w_drem_sh} - {2'b00, r_b};
  assign w_dbit     = ~w_ddiff[WIDTH+1];
  assign w_drem_nxt = w_dbit ? w_ddiff[WIDTH:0] : w_drem_sh;
  assign w_dq_nxt   = WIDTH'({r_q, w_dbit});

  // Non-restoring sqrt step: sign of the partial remainder picks add (4Q+3) or subtract (4Q+1).
  assign w_sr_sh  = SW'({r_sr, r_a[WIDTH-1 -: 2]});
  assign w_sq_t   = r_sr[SW-1] ? SW'({r_q[H-1:0], 2'b11}) : SW'({r_q[H-1:0], 2'b01});
  assign w_sr_nxt = r_sr[SW-1] ? (w_sr_sh + w_sq_t) : (w_sr_sh - w_sq_t);
  assign w_sq_nxt = H'({r_q, ~w_sr_nxt[SW-1]});
  assign w_sr_fix = w_sr_nxt[SW-1] ? (w_sr_nxt + SW'({w_sq_nxt, 1'b1})) : w_sr_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (kill_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
        S_BUSY:  if (w_last) w_state_nxt = S_DONE;
        S_DONE:  w_state_nxt = w_start ? S_BUSY : S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    ready_o = 1'b1;
    done_o  = 1'b0;
    case (r_state)
      S_BUSY:  ready_o = 1'b0;
      S_DONE:  done_o  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_op_div  <= 1'b0;
      r_dbz     <= 1'b0;
      r_drem    <= '0;
      r_sr      <= '0;
      r_q       <= '0;
      r_result  <= '0;
      r_rem     <= '0;
      r_dbz_out <= 1'b0;
    end else if (w_start) begin
      r_a      <= operand_a_i;
      r_b      <= operand_b_i;
      r_op_div <= div_start_i;
      r_dbz    <= div_start_i & (operand_b_i == '0);
      r_drem   <= '0;
      r_sr     <= '0;
      r_q      <= '0;
      r_cnt    <= div_start_i ? CW'(WIDTH - 1) : CW'(H - 1);
    end else if (r_state == S_BUSY && !kill_i) begin
      r_cnt <= r_cnt - 1'b1;
      if (r_op_div) begin
        // A zero divisor freezes the datapath so the dividend survives as the remainder.
        if (!r_dbz) begin
          r_a    <= r_a << 1;
          r_drem <= w_drem_nxt;
          r_q    <= w_dq_nxt;
        end
      end else begin
        r_a  <= r_a << 2;
        r_sr <= w_sr_nxt;
        r_q  <= WIDTH'(w_sq_nxt);
      end
      if (w_last) begin
        r_dbz_out <= r_op_div & r_dbz;
        if (!r_op_div) begin
          r_result <= WIDTH'(w_sq_nxt);
          r_rem    <= WIDTH'(w_sr_fix);
        end else if (r_dbz) begin
          r_result <= '1;
          r_rem    <= r_a;
        end else begin
          r_result <= w_dq_nxt;
          r_rem    <= w_drem_nxt[WIDTH-1:0];
        end
      end
    end
  end

  assign result_o      = r_result;
  assign rem_o         = r_rem;
  assign div_by_zero_o = r_dbz_out;

endmodule

// File: tb/tb_divsqrt_iter_core.sv
// tb/tb_divsqrt_iter_core.sv - scoreboard bench for divsqrt_iter_core
// Stimulus pushes expected completions; a negedge monitor pops and checks them.
module tb_divsqrt_iter_core;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         div_start = 1'b0;
  logic         sqrt_start = 1'b0;
  logic [W-1:0] opa = '0;
  logic [W-1:0] opb = '0;
  logic         kill = 1'b0;
  logic [W-1:0] result;
  logic [W-1:0] rem;
  logic         dbz;
  logic         ready;
  logic         done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         dbz;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  divsqrt_iter_core #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .div_start_i(div_start), .sqrt_start_i(sqrt_start),
    .operand_a_i(opa), .operand_b_i(opb), .kill_i(kill),
    .result_o(result), .rem_o(rem), .div_by_zero_o(dbz), .ready_o(ready), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle and push the expected completion at start cycle + latency.
  task automatic issue(input logic d, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eres, input logic [W-1:0] erem, input logic edbz);
    exp_t e;
    e.res = eres; e.rem = erem; e.dbz = edbz;
    e.cyc = cyc + (d ? W + 1 : W / 2 + 1);
    sb.push_back(e);
    div_start = d; sqrt_start = s; opa = a; opb = b;
    step(1);
    div_start = 1'b0; sqrt_start = 1'b0;
    opa = $urandom; opb = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("rem", rem, e.rem);
        chk("div_by_zero", dbz, e.dbz);
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    step(3);
    rst = 1'b0;
    chk("rst_result", result, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", dbz, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);

    // div 100/7 with busy-window ready check
    issue(1, 0, 100, 7, 14, 2, 0);
    for (int i = 1; i <= 32; i++) begin
      chk("busy_ready", ready, 0);
      step(1);
    end
    chk("done_ready", ready, 1);
    drain();

    issue(0, 1, 1000000, 0, 1000, 0, 0);
    drain();
    issue(0, 1, 32'hFFFF_FFFF, 0, 65535, 131070, 0);
    drain();
    issue(1, 0, 5, 0, 32'hFFFF_FFFF, 5, 1);
    drain();
    issue(1, 0, 9, 3, 3, 0, 0);
    drain();

    // kill in cycle 10 of div 1000/3
    div_start = 1'b1; opa = 1000; opb = 3;
    step(1);
    div_start = 1'b0;
    step(9);
    kill = 1'b1;
    step(1);
    kill = 1'b0;
    chk("kill_ready", ready, 1);
    chk("kill_done", done, 0);
    chk("kill_result", result, 3);
    chk("kill_rem", rem, 0);
    step(40);

    // kill with start in the same cycle
    div_start = 1'b1; kill = 1'b1; opa = 40; opb = 2;
    step(1);
    div_start = 1'b0; kill = 1'b0;
    chk("killstart_ready", ready, 1);
    step(40);
    chk("killstart_result", result, 3);

    // back-to-back: sqrt 49 issued in the DONE cycle of div 10/3
    issue(1, 0, 10, 3, 3, 1, 0);
    step(32);
    chk("b2b_done", done, 1);
    issue(0, 1, 49, 0, 7, 0, 0);
    drain();

    // both starts high: divide wins (sqrt 20 would give 4 rem 4)
    issue(1, 1, 20, 6, 3, 2, 0);
    drain();

    // start during BUSY ignored
    issue(1, 0, 50, 5, 10, 0, 0);
    step(4);
    sqrt_start = 1'b1; opa = 81;
    step(1);
    sqrt_start = 1'b0;
    drain();
    step(20);

    // reset in cycle 5 of a divide
    div_start = 1'b1; opa = 77; opb = 7;
    step(1);
    div_start = 1'b0;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rstbusy_ready", ready, 1);
    chk("rstbusy_done", done, 0);
    chk("rstbusy_result", result, 0);
    chk("rstbusy_rem", rem, 0);
    step(40);
    issue(1, 0, 77, 7, 11, 0, 0);
    drain();
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divsqrt_iter_core.md
# divsqrt_iter_core

Iterative radix-2 unsigned integer divide / square-root core that implements the responder side of the start/ready/done/kill handshake used by our div/sqrt wrappers. The core accepts a one-cycle start pulse, computes one result bit per cycle, and raises a done pulse. It holds the result stable until the next start. It sits under a wrapper FSM that handles operand formatting, hold registers and output pipelining, and it is the bench reference for validating that FSM.

## Interface
Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- div_start_i  in  1  start a divide; sampled only when ready_o=1.
- sqrt_start_i  in  1  start a square root; sampled only when ready_o=1.
- operand_a_i  in  WIDTH  dividend, or radicand for sqrt.
- operand_b_i  in  WIDTH  divisor; ignored for sqrt.
- kill_i  in  1  abort the operation in flight.
- result_o  out  WIDTH  quotient for div; floor(sqrt(a)) zero-extended for sqrt.
- rem_o  out  WIDTH  remainder: a − q·b for div, a − r² for sqrt.
- div_by_zero_o  out  1  set when the last completed div had b=0.
- ready_o  out  1  core can accept a start this cycle.
- done_o  out  1  one-cycle pulse: result_o, rem_o and div_by_zero_o are valid.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE: ready_o=1, done_o=0.
  - BUSY: ready_o=0, done_o=0.
  - DONE: ready_o=1, done_o=1.
- Start acceptance: a start is accepted when (div_start_i | sqrt_start_i) & ready_o & ~kill_i.
  - On acceptance, the core latches the operands and the op, clears the partial remainder and quotient, loads the iteration counter, and enters BUSY.
  - Starts while ready_o=0 are ignored.
- Both start inputs high together: divide wins. This is a protocol violation, but it is defined.
- Divide:
  - Restoring, MSB-first, WIDTH iterations.
  - The partial remainder is WIDTH+1 bits.
  - Each iteration shifts in the next dividend bit, trial-subtracts b, and on a non-negative result keeps the difference and sets the quotient bit.
- Divide by b=0:
  - No iterations run; the core still takes the full WIDTH iterations of latency.
  - result_o is all ones, rem_o = a, div_by_zero_o = 1.
- Square root:
  - Non-restoring, digit-by-digit, WIDTH/2 iterations.
  - Each iteration consumes 2 radicand bits and produces 1 root bit.
  - The remainder is at most WIDTH/2+1 bits, zero-extended onto rem_o.
- div_by_zero_o is 0 for every sqrt and every div with b≠0.
- Result hold: result_o, rem_o and div_by_zero_o update only on the edge that enters DONE. They hold through DONE and IDLE and until the next completion.
- BUSY → DONE transition: taken when the counter reaches its final iteration.
- DONE next-state rules:
  - DONE → BUSY if a new start is accepted in the DONE cycle (back-to-back).
  - Otherwise DONE → IDLE.
- Kill:
  - kill_i=1 in any state forces IDLE on the next edge.
  - No done_o is produced for the killed operation, and result_o/rem_o keep their previous values.
  - Kill wins over a start in the same cycle.
- Reset: state IDLE, result_o=0, rem_o=0, div_by_zero_o=0, ready_o=1 (combinational from IDLE), done_o=0.

## Timing
- Cycle 0 is the cycle in which the start is accepted.
- Divide: done_o is high in cycle WIDTH+1 (cycle 33 for WIDTH=32).
- Sqrt: done_o is high in cycle WIDTH/2+1 (cycle 17 for WIDTH=32).
- done_o is high for exactly one cycle per completed operation.
- ready_o and done_o are pure decodes of state; no input-to-output combinational path exists.
- Throughput: a start accepted in the DONE cycle begins immediately, giving one result per WIDTH+1 cycles for div and WIDTH/2+1 cycles for sqrt.
- Operands need only be valid in the start cycle; the core ignores operand changes during BUSY.
- rst_i during BUSY: IDLE on the next edge, results cleared to 0, no done_o.

## Test plan
- Divide: div 100/7, WIDTH=32 → done_o only in cycle 33; result_o=14, rem_o=2, div_by_zero_o=0; ready_o=0 in cycles 1–32.
- Sqrt, exact and maximum radicand:
  - sqrt a=1000000 → done_o in cycle 17; result_o=1000, rem_o=0.
  - sqrt a=0xFFFFFFFF → result_o=65535, rem_o=131070.
- Divide by zero: div 5/0 → done_o in cycle 33; result_o=0xFFFFFFFF, rem_o=5, div_by_zero_o=1. A following div 9/3 then gives result_o=3, rem_o=0, div_by_zero_o=0.
- Kill mid-operation: start div 1000/3, kill_i=1 in cycle 10 → IDLE and ready_o=1 in cycle 11; no done_o; result_o/rem_o keep the prior values. Also check kill_i together with a start in the same cycle → start ignored.
- Back-to-back and start rules:
  - Back-to-back: start sqrt 49 in the DONE cycle of div 10/3 → div reports 3/1; sqrt done_o follows 17 cycles later with result_o=7, rem_o=0.
  - Both starts high together → divide is executed.
  - A start during BUSY → ignored.
- Reset during BUSY: rst_i=1 in cycle 5 of a div → IDLE next cycle, result_o=0, rem_o=0, no done_o; a new op afterwards completes correctly.
